// File: rtl/parallel_bus_initiator_pkg.sv
// Shared encodings and helpers for the strobed parallel bus initiator.
// Holds FSM states, beat kinds and slice indexing (shared with the responder).
package parallel_bus_initiator_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RELEASE,
    S_GAP,
    S_FINISH
  } state_e;

  localparam logic BEAT_ADDR = 1'b0;
  localparam logic BEAT_DATA = 1'b1;

  // LSB position of word slice 'slice' for a bus of 'width' bits.
  function automatic int slice_lsb(int slice, int width);
    return slice * width;
  endfunction

  function automatic int max_of(int a, int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parallel_bus_initiator_if.sv
// Command and bus signals of the parallel bus initiator.
// master: initiator view; slave: command source + responder view.
interface parallel_bus_initiator_if #(
  parameter int WIDTH                 = 8,
  parameter int TRANSACTIONS_PER_WORD = 2
);
  localparam int WW = WIDTH * TRANSACTIONS_PER_WORD;

  logic             start;
  logic             rw;
  logic [WIDTH-1:0] cmd_address;
  logic [WW-1:0]    cmd_write_word;
  logic             busy;
  logic             done;
  logic             error;
  logic [WW-1:0]    read_word;
  logic [WIDTH-1:0] bus_out;
  logic             bus_oe;
  logic [WIDTH-1:0] bus_in;
  logic             read;
  logic             register_select;
  logic             enable;
  logic             ack_valid;

  modport master (
    input  start, rw, cmd_address, cmd_write_word,
    input  bus_in, ack_valid,
    output busy, done, error, read_word,
    output bus_out, bus_oe, read,
    output register_select, enable
  );

  modport slave (
    output start, rw, cmd_address, cmd_write_word,
    output bus_in, ack_valid,
    input  busy, done, error, read_word,
    input  bus_out, bus_oe, read,
    input  register_select, enable
  );

endinterface

// File: rtl/parallel_bus_initiator_sync.sv
// ack_synchronizer: 2-flop synchronizer for the asynchronous ack line.
// Ports: clock_i, reset_i (sync, active-high), async_i, sync_o.
module ack_synchronizer (
  input  logic clock_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/parallel_bus_initiator.sv
// parallel_bus_initiator: turns one read/write command into an address
// beat plus TRANSACTIONS_PER_WORD data beats (MS slice first).
// Ports: clock, reset (sync, active-high), bus (master modport).
// Macro PARALLEL_BUS_ACK_TIMEOUT_EN: abort with error after ACK_TIMEOUT
// cycles waiting on ack in STROBE/RELEASE; otherwise wait forever.
module parallel_bus_initiator
  import parallel_bus_initiator_pkg::*;
#(
  parameter int WIDTH                 = 8,
  parameter int TRANSACTIONS_PER_WORD = 2,
  parameter int SETUP_CYCLES          = 2,
  parameter int HOLD_CYCLES           = 4,
  parameter int GAP_CYCLES            = 2,
  parameter int ACK_TIMEOUT           = 255
) (
  input logic clock,
  input logic reset,
  parallel_bus_initiator_if.master bus
);

  localparam int T  = TRANSACTIONS_PER_WORD;
  localparam int WW = WIDTH * T;
  localparam int SW = (T > 1) ? $clog2(T) : 1;
  localparam int CW = $clog2(max_of(max_of(SETUP_CYCLES, HOLD_CYCLES),
                                    max_of(GAP_CYCLES, ACK_TIMEOUT)) + 1);
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             beat_q, beat_d;
  logic [SW-1:0]    slice_q, slice_d;
  logic             rw_q, rw_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WW-1:0]    word_q, word_d;
  logic [WW-1:0]    rdata_q, rdata_d;
  logic             low_q, low_d;
  logic             ack_s;

  ack_synchronizer u_sync (
    .clock_i (clock),
    .reset_i (reset),
    .async_i (bus.ack_valid),
    .sync_o  (ack_s)
  );

`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
  logic err_q, err_d;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      beat_q  <= BEAT_ADDR;
      slice_q <= '0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      low_q   <= 1'b0;
`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      slice_q <= slice_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      low_q   <= low_d;
`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    beat_d  = beat_q;
    slice_d = slice_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    low_d   = low_q;
`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
    err_d   = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          rw_d    = bus.rw;
          addr_d  = bus.cmd_address;
          word_d  = bus.cmd_write_word;
          beat_d  = BEAT_ADDR;
          slice_d = SW'(T - 1);
          cnt_d   = '0;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CW'(SETUP_CYCLES - 1)) begin
          cnt_d   = '0;
          low_d   = 1'b0;
          state_d = S_STROBE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STROBE: begin
        // A stale high ack must drop first: only a low->high
        // seen after enable rose counts as this beat's ack.
        if (!ack_s) low_d = 1'b1;
        if (ack_s && low_q) begin
          cnt_d   = '0;
          state_d = S_HOLD;
        end else begin
`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
          if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
      end
      S_HOLD: begin
        if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = S_RELEASE;
          if (rw_q && beat_q == BEAT_DATA)
            rdata_d[slice_lsb(int'(slice_q), WIDTH) +: WIDTH] = bus.bus_in;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RELEASE: begin
        if (!ack_s) begin
          cnt_d   = '0;
          state_d = S_GAP;
        end else begin
`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
          if (cnt_q == CW'(ACK_TIMEOUT - 1)) begin
            cnt_d   = '0;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
`endif
        end
      end
      S_GAP: begin
        if (cnt_q == CW'(GAP_LAST)) begin
          cnt_d = '0;
          if (beat_q == BEAT_ADDR) begin
            beat_d  = BEAT_DATA;
            state_d = S_SETUP;
          end else if (slice_q == '0) begin
            state_d = S_FINISH;
          end else begin
            slice_d = slice_q - SW'(1);
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  logic is_addr;
  logic drive;
  logic in_beat;

  assign is_addr = (beat_q == BEAT_ADDR);
  assign drive   = (state_q == S_SETUP) || (state_q == S_STROBE) ||
                   (state_q == S_HOLD);
  // RELEASE/GAP keep read and register_select but never drive the
  // bus, so bus_oe is always low a cycle before read can rise.
  assign in_beat = drive || (state_q == S_RELEASE) ||
                   (state_q == S_GAP);

  assign bus.bus_oe          = drive && (is_addr || !rw_q);
  assign bus.read            = in_beat && rw_q && !is_addr;
  assign bus.register_select = in_beat && !is_addr;
  assign bus.enable          = (state_q == S_STROBE) ||
                               (state_q == S_HOLD);
  assign bus.bus_out         = !bus.bus_oe ? '0 :
                               is_addr ? addr_q :
                               word_q[slice_lsb(int'(slice_q), WIDTH) +: WIDTH];
  assign bus.busy            = (state_q != S_IDLE) &&
                               (state_q != S_FINISH);
  assign bus.done            = (state_q == S_FINISH);
  assign bus.read_word       = rdata_q;

`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
  assign bus.error = err_q;
`else
  assign bus.error = 1'b0;
`endif

endmodule

// File: tb/tb_parallel_bus_initiator.sv
// Bench for parallel_bus_initiator with a behavioural responder.
// Scoreboard of expected results is checked on every done pulse.
module tb_parallel_bus_initiator;

  localparam int ATO = 20;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  parallel_bus_initiator_if #(.WIDTH(8), .TRANSACTIONS_PER_WORD(2)) bif ();

  parallel_bus_initiator #(
    .WIDTH(8), .TRANSACTIONS_PER_WORD(2), .SETUP_CYCLES(2),
    .HOLD_CYCLES(4), .GAP_CYCLES(2), .ACK_TIMEOUT(ATO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct {
    bit          rd;
    logic [7:0]  addr;
    logic [15:0] exp;
  } sb_t;

  sb_t         sbq[$];
  logic [9:0]  blog[$];
  logic [15:0] ram     [256];
  logic [15:0] ref_mem [256];
  int n_chk = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int viol = 0;
  bit ack_block = 1'b0;
  logic prev_rd = 1'b0;
  logic prev_oe = 1'b0;
  logic [15:0] last_rd = 16'h0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Responder: latch the beat, ack one cycle later, drop ack after enable.
  initial begin : responder
    logic [7:0]  r_addr;
    logic [15:0] r_word;
    int r_cnt;
    r_addr = 0; r_word = 0; r_cnt = 0;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 16'h0;
      ref_mem[i] = 16'h0;
    end
    bif.ack_valid = 1'b0;
    bif.bus_in = 8'h0;
    forever begin
      @(negedge clock);
      if (bif.enable && !ack_block) begin
        if (!bif.register_select) begin
          r_addr = bif.bus_out;
          r_cnt = 0;
        end else if (!bif.read) begin
          r_word = {r_word[7:0], bif.bus_out};
          r_cnt++;
          if (r_cnt == 2) ram[r_addr] = r_word;
        end else begin
          bif.bus_in = ram[r_addr][(1 - r_cnt) * 8 +: 8];
          r_cnt++;
        end
        blog.push_back({bif.register_select, bif.read,
                        bif.read ? bif.bus_in : bif.bus_out});
        @(negedge clock);
        bif.ack_valid = 1'b1;
        for (int i = 0; i < 1000 && bif.enable; i++) @(negedge clock);
        bif.ack_valid = 1'b0;
      end
    end
  end

  // Bus-direction rules and scoreboard checks on completion.
  always @(negedge clock) begin
    if (bif.read && bif.bus_oe) viol <= viol + 1;
    if (bif.read && !prev_rd && prev_oe) viol <= viol + 1;
    prev_rd <= bif.read;
    prev_oe <= bif.bus_oe;
    if (!reset && bif.done) begin
      done_cnt++;
      chk("sb_nonempty", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        sb_t e;
        e = sbq.pop_front();
        if (e.rd) begin
          chk($sformatf("rd_%h", e.addr), bif.read_word, e.exp);
          last_rd = e.exp;
        end else begin
          chk($sformatf("ram_%h", e.addr), ram[e.addr], e.exp);
          ref_mem[e.addr] = e.exp;
        end
      end
    end
  end

  task automatic issue(input bit r, input logic [7:0] a,
                       input logic [15:0] w);
    for (int n = 0; n < 2000 && (bif.busy || bif.done); n++)
      @(negedge clock);
    bif.rw = r;
    bif.cmd_address = a;
    bif.cmd_write_word = w;
    bif.start = 1'b1;
    sbq.push_back('{r, a, r ? ref_mem[a] : w});
    @(negedge clock);
    bif.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int n);
    for (int i = 0; i < 3000 && done_cnt - d0 < n; i++)
      @(negedge clock);
    chk(tag, done_cnt - d0, n);
  endtask

  initial begin
    int d0;
    int cnt;
    bif.start = 1'b0;
    bif.rw = 1'b0;
    bif.cmd_address = 8'h0;
    bif.cmd_write_word = 16'h0;
    repeat (3) @(negedge clock);
    chk("rst_busy", bif.busy, 0);
    chk("rst_done", bif.done, 0);
    chk("rst_error", bif.error, 0);
    chk("rst_enable", bif.enable, 0);
    chk("rst_oe_rd_rs", {bif.bus_oe, bif.read, bif.register_select}, 0);
    chk("rst_bus_out", bif.bus_out, 0);
    chk("rst_read_word", bif.read_word, 0);
    reset = 1'b0;
    @(negedge clock);

    // single write: check the exact beat sequence
    blog.delete();
    d0 = done_cnt;
    issue(0, 8'h4c, 16'h2a12);
    wait_done("wr4c_done", d0, 1);
    chk("wr4c_nbeats", blog.size(), 3);
    if (blog.size() == 3) begin
      chk("beat0", blog[0], {2'b00, 8'h4c});
      chk("beat1", blog[1], {2'b10, 8'h2a});
      chk("beat2", blog[2], {2'b10, 8'h12});
    end

    // write then read back
    d0 = done_cnt;
    issue(0, 8'h4d, 16'h2b34);
    wait_done("wr4d_done", d0, 1);
    d0 = done_cnt;
    issue(1, 8'h4d, 16'h0);
    wait_done("rd4d_done", d0, 1);

    // start while busy is dropped
    blog.delete();
    d0 = done_cnt;
    issue(0, 8'h50, 16'h1111);
    repeat (5) @(negedge clock);
    chk("busy_mid", bif.busy, 1);
    bif.cmd_address = 8'h51;
    bif.cmd_write_word = 16'h9999;
    bif.start = 1'b1;
    @(negedge clock);
    bif.start = 1'b0;
    wait_done("wr50_done", d0, 1);
    repeat (80) @(negedge clock);
    chk("ignored_nbeats", blog.size(), 3);
    chk("ignored_ram51", ram[8'h51], 16'h0);
    chk("ignored_busy", bif.busy, 0);
    chk("ignored_done", done_cnt - d0, 1);

    // reset in the first data beat
    issue(0, 8'h60, 16'hbeef);
    for (int i = 0; i < 500 && !(bif.enable && bif.register_select); i++)
      @(negedge clock);
    chk("abort_reached", bif.enable && bif.register_select, 1);
    d0 = done_cnt;
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_enable", bif.enable, 0);
    chk("abort_oe", bif.bus_oe, 0);
    chk("abort_busy", bif.busy, 0);
    sbq.delete();
    repeat (40) @(negedge clock);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_ram60", ram[8'h60], 16'h0);

    // fill, then back-to-back reads
    d0 = done_cnt;
    issue(0, 8'h4e, 16'h2c56);
    issue(0, 8'h4f, 16'h2d78);
    wait_done("wr4e4f_done", d0, 2);
    d0 = done_cnt;
    for (int a = 8'h4c; a <= 8'h4f; a++) issue(1, 8'(a), 16'h0);
    wait_done("rd_b2b_done", d0, 4);

    // responder silent
    ack_block = 1'b1;
    issue(1, 8'h4c, 16'h0);
    sbq.delete();
    for (int i = 0; i < 200 && !bif.enable; i++) @(negedge clock);
`ifdef PARALLEL_BUS_ACK_TIMEOUT_EN
    cnt = 0;
    for (int i = 0; i < 300 && !bif.error; i++) begin
      if (bif.enable) cnt++;
      @(negedge clock);
    end
    chk("to_error", bif.error, 1);
    chk("to_cycles", cnt, ATO);
    chk("to_busy", bif.busy, 0);
    chk("to_bus", {bif.enable, bif.bus_oe, bif.read}, 0);
    chk("to_read_word", bif.read_word, last_rd);
    @(negedge clock);
    chk("to_err_pulse", bif.error, 0);
`else
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bif.busy && !bif.error) cnt++;
      @(negedge clock);
    end
    chk("noto_busy", cnt, 100);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
`endif
    ack_block = 1'b0;

    chk("oe_read_rules", viol, 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
